// File: rtl/lb_spram_fifo_ctrl.sv
// Stream FIFO controller around a 64x32 single-port SRAM with a 2-entry output buffer.
// Define SPRAM_FIFO_BYPASS_EN to let pushes skip the SRAM when it and the read pipe are empty.
module lb_spram_fifo_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic [6:0]    level,
  output logic          ram_ceb,
  output logic          ram_web,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic [3:0]    ram_bweb,
  input  logic [DW-1:0] ram_q
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_count_q, ram_count_d;
  logic          inflight_q, inflight_d;
  logic [DW-1:0] ob0_q, ob0_d;
  logic [DW-1:0] ob1_q, ob1_d;
  logic [1:0]    ob_count_q, ob_count_d;

  logic          pop_fire;
  logic          push_fire;
  logic [1:0]    ob_after_pop;
  logic          read_req;
  logic          read_urgent;
  logic          bypass_ok;
  logic          do_bypass;
  logic          do_write;
  logic          do_read;
  logic          fill_en;
  logic [DW-1:0] fill_data;

  // Arbitration: everything is judged on the output-buffer occupancy left after this cycle's pop.
  always_comb begin
    pop_fire     = (ob_count_q != 2'd0) && pop_ready;
    ob_after_pop = ob_count_q - {1'b0, pop_fire};
    read_req     = (ram_count_q != '0) &&
                   (({1'b0, ob_after_pop} + {2'b00, inflight_q}) < 3'd2);
    read_urgent  = read_req && (ob_after_pop == 2'd0) && !inflight_q;
`ifdef SPRAM_FIFO_BYPASS_EN
    bypass_ok    = (ram_count_q == '0) && !inflight_q && (ob_after_pop < 2'd2);
`else
    bypass_ok    = 1'b0;
`endif
    push_ready   = bypass_ok ||
                   ((ram_count_q < (AW+1)'(DEPTH)) && !read_urgent);
    push_fire    = push_valid && push_ready;
    do_bypass    = push_fire && bypass_ok;
    do_write     = push_fire && !bypass_ok;
    do_read      = !push_fire && read_req;
    fill_en      = inflight_q || do_bypass;
    fill_data    = inflight_q ? ram_q : push_data;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    inflight_d  = do_read;
    ob0_d       = ob0_q;
    ob1_d       = ob1_q;
    ob_count_d  = ob_after_pop + {1'b0, fill_en};
    if (do_write) begin
      wr_ptr_d    = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
      ram_count_d = ram_count_q + (AW+1)'(1);
    end
    if (do_read) begin
      rd_ptr_d    = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);
      ram_count_d = ram_count_q - (AW+1)'(1);
    end
    if (pop_fire) begin
      ob0_d = ob1_q;
    end
    // The fill lands in the first slot left free once the pop has shifted the buffer.
    if (fill_en) begin
      if (ob_after_pop == 2'd0) begin
        ob0_d = fill_data;
      end else begin
        ob1_d = fill_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      ob0_q       <= '0;
      ob1_q       <= '0;
      ob_count_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
      ob0_q       <= ob0_d;
      ob1_q       <= ob1_d;
      ob_count_q  <= ob_count_d;
    end
  end

  always_comb begin
    pop_valid = (ob_count_q != 2'd0);
    pop_data  = ob0_q;
    level     = 7'(ram_count_q) + 7'(ob_count_q) + 7'(inflight_q);
    ram_ceb   = !(do_write || do_read);
    ram_web   = !do_write;
    ram_a     = do_write ? wr_ptr_q : rd_ptr_q;
    ram_d     = push_data;
    ram_bweb  = '0;
  end

endmodule

// File: tb/tb_lb_spram_fifo_ctrl.sv
// Self-checking bench for lb_spram_fifo_ctrl with a behavioural SRAM and a data scoreboard.
// Expectations follow SPRAM_FIFO_BYPASS_EN when it is defined for the build.
module tb_lb_spram_fifo_ctrl;

`ifdef SPRAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_data = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic [6:0]  level;
  logic        ram_ceb;
  logic        ram_web;
  logic [5:0]  ram_a;
  logic [31:0] ram_d;
  logic [3:0]  ram_bweb;
  logic [31:0] ram_q = '0;

  logic [31:0] mem [64];
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          pop_cnt = 0;

  always #5 clk = ~clk;

  lb_spram_fifo_ctrl #(.DEPTH(64), .AW(6), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .level(level),
    .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_a(ram_a),
    .ram_d(ram_d), .ram_bweb(ram_bweb), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (!ram_ceb) begin
      if (!ram_web) mem[ram_a] <= ram_d;
      else          ram_q      <= mem[ram_a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pushes are queued, pops must return the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ram_bweb", {28'd0, ram_bweb}, 32'd0);
      if (pop_valid && pop_ready) begin
        pop_cnt++;
        if (sb.size() == 0) check("pop_unexpected", pop_data, 32'hFFFF_FFFF);
        else                check("pop_data", pop_data, sb.pop_front());
      end
      if (push_valid && push_ready) sb.push_back(push_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    push_valid = 1'b0;
    pop_ready = 1'b0;
    push_data = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] d);
    int unsigned t = 0;
    bit done = 1'b0;
    push_valid = 1'b1;
    push_data = d;
    while (!done) begin
      @(negedge clk);
      if (push_ready) done = 1'b1;
      else if (++t > 200) begin
        check("push_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    push_valid = 1'b0;
    pop_ready = 1'b1;
    while ((sb.size() != 0 || pop_valid) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", sb.size(), 32'd0);
    pop_ready = 1'b0;
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pd;
    logic        pr;
    logic        e_prdy;
    logic        e_pval;
    logic [31:0] e_pdata;
    logic [6:0]  e_lvl;
    logic        e_ceb;
    logic        e_web;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int pops0;
    logic [31:0] nd;
    bit acc;

    vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, BYP, BYP};
    vecs[1] = '{1'b0, 32'h0, 1'b0, BYP, BYP, 32'hA5A5_0001, 7'd1, BYP, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, BYP, 32'hA5A5_0001, 7'd1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 7'd1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 7'd1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b1, 1'b1};

    do_reset();
    @(negedge clk);
    check("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
    check("rst_pop_data", pop_data, 32'd0);
    check("rst_level", {25'd0, level}, 32'd0);
    check("rst_ram_ceb", {31'd0, ram_ceb}, 32'd1);
    check("rst_ram_web", {31'd0, ram_web}, 32'd1);
    check("rst_ram_a", {26'd0, ram_a}, 32'd0);
    check("rst_push_ready", {31'd0, push_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single push from empty, then pop it.
    for (int i = 0; i < 6; i++) begin
      push_valid = vecs[i].pv;
      push_data  = vecs[i].pd;
      pop_ready  = vecs[i].pr;
      @(negedge clk);
      check($sformatf("v%0d_push_ready", i), {31'd0, push_ready}, {31'd0, vecs[i].e_prdy});
      check($sformatf("v%0d_pop_valid", i), {31'd0, pop_valid}, {31'd0, vecs[i].e_pval});
      if (vecs[i].e_pval) check($sformatf("v%0d_pop_data", i), pop_data, vecs[i].e_pdata);
      check($sformatf("v%0d_level", i), {25'd0, level}, {25'd0, vecs[i].e_lvl});
      check($sformatf("v%0d_ram_ceb", i), {31'd0, ram_ceb}, {31'd0, vecs[i].e_ceb});
      check($sformatf("v%0d_ram_web", i), {31'd0, ram_web}, {31'd0, vecs[i].e_web});
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
    pop_ready = 1'b0;

    // Fill to capacity, confirm full and idle, then drain through the pointer wrap.
    do_reset();
    for (int i = 0; i < 66; i++) push_word(32'(i));
    push_valid = 1'b1;
    push_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_push_ready", {31'd0, push_ready}, 32'd0);
      check("full_ram_ceb", {31'd0, ram_ceb}, 32'd1);
      check("full_level", {25'd0, level}, 32'd66);
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
    pops0 = pop_cnt;
    drain();
    check("fill_pop_count", 32'(pop_cnt - pops0), 32'd66);

    // Sustained push+pop from half full.
    do_reset();
    for (int i = 0; i < 32; i++) push_word(32'h1000 + 32'(i));
    @(negedge clk);
    check("half_level", {25'd0, level}, 32'd32);
    @(posedge clk);
    #1;
    nd = 32'h1020;
    pops0 = pop_cnt;
    push_valid = 1'b1;
    pop_ready = 1'b1;
    push_data = nd;
    repeat (200) begin
      @(negedge clk);
      acc = push_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nd = nd + 32'd1;
        push_data = nd;
      end
    end
    check("throughput_ge_100", {31'd0, (pop_cnt - pops0) >= 100}, 32'd1);
    drain();

    // Pop empties the buffer while the SRAM holds 5 words: the read takes the port.
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'h200 + 32'(i));
    if (BYP) begin
      pop_ready = 1'b1;
      push_word(32'h206);
    end
    pop_ready = 1'b1;
    push_valid = 1'b1;
    push_data = 32'h300;
    @(negedge clk);
    check("urg_level", {25'd0, level}, 32'd6);
    check("urg_push_ready", {31'd0, push_ready}, 32'd0);
    check("urg_ram_ceb", {31'd0, ram_ceb}, 32'd0);
    check("urg_ram_web", {31'd0, ram_web}, 32'd1);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_ready = 1'b0;
    @(negedge clk);
    check("urg_pop_valid_t1", {31'd0, pop_valid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("urg_pop_valid_t2", {31'd0, pop_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Reset while a read is in flight: the returning word must be discarded.
    do_reset();
    for (int i = 0; i < 11; i++) push_word(32'h400 + 32'(i));
    pop_ready = 1'b1;
    @(negedge clk);
    check("rr_read_ceb", {31'd0, ram_ceb}, 32'd0);
    check("rr_read_web", {31'd0, ram_web}, 32'd1);
    @(posedge clk);
    #1;
    pop_ready = 1'b0;
    @(negedge clk);
    check("rr_level_before", {25'd0, level}, 32'd10);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rr_level_in_reset", {25'd0, level}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pop_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_pop_valid", {31'd0, pop_valid}, 32'd0);
      check("rr_level", {25'd0, level}, 32'd0);
      check("rr_ram_ceb", {31'd0, ram_ceb}, 32'd1);
      @(posedge clk);
      #1;
    end
    pop_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
